// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// The grant-source enum names which requester owns the write port this cycle.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_MD
  } gnt_src_e;

endpackage

// File: rtl/md_result_fifo.sv
// Small FIFO that buffers mul/div results ({rd, data}) until they win the
// register-file write port. A push while full or a pop while empty is ignored.
module md_result_fifo
  import regfile_pkg::*;
#(
  parameter int WIDTH = regfile_pkg::ADDR_W + regfile_pkg::DATA_W,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between WB and the mul/div
// result FIFO, registers the winning write, and tracks in-flight mul/div rd's.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W    = regfile_pkg::DATA_W,
  parameter int ADDR_W    = regfile_pkg::ADDR_W,
  parameter int NREGS     = regfile_pkg::NREGS,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              md_issue_valid,
  input  logic [ADDR_W-1:0] md_issue_rd,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              rf_writeenable,
  output logic [ADDR_W-1:0] rf_reg_write,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [ADDR_W-1:0] sb_rs1,
  input  logic [ADDR_W-1:0] sb_rs2,
  input  logic [ADDR_W-1:0] sb_rd,
  output logic              sb_hazard
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RZ = ADDR_W'(REG_ZERO);

  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_push;
  logic              fifo_pop;

  gnt_src_e          gnt;
  logic [ADDR_W-1:0] gnt_rd;
  logic [DATA_W-1:0] gnt_data;
  logic              wr_commit;

  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;

  md_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({md_rd, md_data}),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_rd, head_data} = head;

  // Both readies reflect the count at the start of the cycle, so a push
  // arriving while full is refused even though the head pops that cycle.
  assign md_ready  = ~fifo_full;
  assign wb_ready  = ~fifo_full;
  assign fifo_push = md_valid & md_ready;

  always_comb begin
    gnt      = GNT_NONE;
    gnt_rd   = '0;
    gnt_data = '0;
    if (fifo_count == CNT_W'(BUF_DEPTH)) gnt = GNT_MD;
    else if (wb_valid)                   gnt = GNT_WB;
    else if (!fifo_empty)                gnt = GNT_MD;
    case (gnt)
      GNT_WB: begin
        gnt_rd   = wb_rd;
        gnt_data = wb_data;
      end
      GNT_MD: begin
        gnt_rd   = head_rd;
        gnt_data = head_data;
      end
      default: ;
    endcase
  end

  assign fifo_pop  = (gnt == GNT_MD);
  assign wr_commit = (gnt != GNT_NONE) && (gnt_rd != RZ);

  // x0 writes complete their handshake but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_writeenable <= 1'b0;
      rf_reg_write   <= '0;
      rf_write_data  <= '0;
    end else begin
      rf_writeenable <= wr_commit;
      if (wr_commit) begin
        rf_reg_write  <= gnt_rd;
        rf_write_data <= gnt_data;
      end
    end
  end

  // Clear on FIFO grant first so a same-cycle issue to that rd wins.
  always_comb begin
    busy_next = busy;
    if (fifo_pop) busy_next[head_rd] = 1'b0;
    if (md_issue_valid && (md_issue_rd != RZ)) busy_next[md_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign sb_hazard = busy[sb_rs1] | busy[sb_rs2] | busy[sb_rd];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes are queued as the
// stimulus is issued and a separate monitor checks each rf_* write in order.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ready;
  logic        md_issue_valid = 1'b0;
  logic [4:0]  md_issue_rd = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready;
  logic        rf_writeenable;
  logic [4:0]  rf_reg_write;
  logic [31:0] rf_write_data;
  logic [4:0]  sb_rs1 = '0;
  logic [4:0]  sb_rs2 = '0;
  logic [4:0]  sb_rd = '0;
  logic        sb_hazard;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  regfile_write_arbiter u_dut (
    .clk            (clk),
    .rst            (rst),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_ready       (wb_ready),
    .md_issue_valid (md_issue_valid),
    .md_issue_rd    (md_issue_rd),
    .md_valid       (md_valid),
    .md_rd          (md_rd),
    .md_data        (md_data),
    .md_ready       (md_ready),
    .rf_writeenable (rf_writeenable),
    .rf_reg_write   (rf_reg_write),
    .rf_write_data  (rf_write_data),
    .sb_rs1         (sb_rs1),
    .sb_rs2         (sb_rs2),
    .sb_rd          (sb_rd),
    .sb_hazard      (sb_hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic exp_push(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: every committed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && rf_writeenable) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got rd=%0d data=%h required no write", rf_reg_write, rf_write_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_reg_write, rf_write_data} !== e) begin
          n_err++;
          $display("FAIL write_order: got rd=%0d data=%h required rd=%0d data=%h",
                   rf_reg_write, rf_write_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wb_cnt;
    int md_idx;
    logic wb_acc;
    logic md_acc;

    // Reset then idle
    #2;
    chk("rst_we", rf_writeenable, 0);
    chk("rst_addr", rf_reg_write, 0);
    chk("rst_data", rf_write_data, 0);
    #8 rst = 1'b0;
    tick();
    chk("idle_wb_ready", wb_ready, 1);
    chk("idle_md_ready", md_ready, 1);
    sb_rs1 = 5'd7; sb_rs2 = 5'd31; sb_rd = 5'd1;
    #1 chk("idle_hazard_a", sb_hazard, 0);
    sb_rs1 = 5'd0; sb_rs2 = 5'd12; sb_rd = 5'd20;
    #1 chk("idle_hazard_b", sb_hazard, 0);
    sb_rs1 = 5'd0; sb_rs2 = 5'd0; sb_rd = 5'd0;

    // WB-only write
    tick();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    exp_push(5'd5, 32'hDEADBEEF);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("wb_we_pulse", rf_writeenable, 1);
    chk("wb_addr", rf_reg_write, 5);
    tick();
    @(negedge clk);
    chk("wb_we_drop", rf_writeenable, 0);

    // Scoreboard lifecycle on rd=7
    tick();
    md_issue_valid = 1'b1; md_issue_rd = 5'd7; sb_rs1 = 5'd7;
    @(negedge clk);
    chk("sb_no_same_cycle", sb_hazard, 0);
    tick();
    md_issue_valid = 1'b0;
    @(negedge clk);
    chk("sb_set", sb_hazard, 1);
    tick(); tick(); tick();
    @(negedge clk);
    chk("sb_hold", sb_hazard, 1);
    tick();
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h12345678;
    exp_push(5'd7, 32'h12345678);
    tick();
    md_valid = 1'b0;
    @(negedge clk);
    chk("sb_in_fifo", sb_hazard, 1);
    tick();
    @(negedge clk);
    chk("sb_clear", sb_hazard, 0);
    chk("sb_commit_we", rf_writeenable, 1);

    // Same-cycle set and clear on rd=11: set wins
    tick();
    md_issue_valid = 1'b1; md_issue_rd = 5'd11; sb_rs1 = 5'd0; sb_rd = 5'd11;
    tick();
    md_issue_valid = 1'b0;
    md_valid = 1'b1; md_rd = 5'd11; md_data = 32'h000000B1;
    exp_push(5'd11, 32'h000000B1);
    tick();
    md_valid = 1'b0;
    md_issue_valid = 1'b1; md_issue_rd = 5'd11;
    tick();
    md_issue_valid = 1'b0;
    @(negedge clk);
    chk("sb_set_wins", sb_hazard, 1);
    tick();
    md_valid = 1'b1; md_rd = 5'd11; md_data = 32'h000000B2;
    exp_push(5'd11, 32'h000000B2);
    tick();
    md_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("sb_reclear", sb_hazard, 0);
    sb_rd = 5'd0;
    drain("drain_sb");

    // Contention: WB held busy, three mul/div results back-to-back
    exp_push(5'd3, 32'h300);
    exp_push(5'd3, 32'h301);
    exp_push(5'd8, 32'hA0000000);
    exp_push(5'd3, 32'h302);
    exp_push(5'd9, 32'hA0000001);
    exp_push(5'd3, 32'h303);
    exp_push(5'd10, 32'hA0000002);
    tick();
    wb_cnt = 0; md_idx = 0;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h300;
    md_valid = 1'b1; md_rd = 5'd8; md_data = 32'hA0000000;
    for (int c = 0; c < 40 && (wb_cnt < 4 || md_idx < 3); c++) begin
      @(negedge clk);
      if (c < 2) chk("cont_md_ready_early", md_ready, 1);
      if (c == 2) begin
        chk("cont_md_ready_full", md_ready, 0);
        chk("cont_wb_ready_full", wb_ready, 0);
      end
      wb_acc = wb_valid && wb_ready;
      md_acc = md_valid && md_ready;
      tick();
      if (wb_acc) begin
        wb_cnt++;
        wb_valid = (wb_cnt < 4);
        wb_data  = 32'h300 + 32'(wb_cnt);
      end
      if (md_acc) begin
        md_idx++;
        md_valid = (md_idx < 3);
        md_rd    = 5'(8 + md_idx);
        md_data  = 32'hA0000000 + 32'(md_idx);
      end
    end
    wb_valid = 1'b0; md_valid = 1'b0;
    chk("cont_all_accepted", {wb_cnt[15:0], md_idx[15:0]}, {16'd4, 16'd3});
    drain("drain_cont");

    // x0 suppression
    tick();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h5;
    md_issue_valid = 1'b1; md_issue_rd = 5'd0;
    sb_rs1 = 5'd0; sb_rs2 = 5'd0; sb_rd = 5'd0;
    tick();
    wb_valid = 1'b0; md_valid = 1'b0; md_issue_valid = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("x0_hazard", sb_hazard, 0);
    chk("x0_fifo_empty", 32'(u_dut.u_fifo.count), 0);
    chk("x0_busy0", 32'(u_dut.busy[0]), 0);
    chk("x0_md_ready", md_ready, 1);

    // Async reset mid-operation
    tick();
    md_issue_valid = 1'b1; md_issue_rd = 5'd7; sb_rs1 = 5'd7;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    md_valid = 1'b1; md_rd = 5'd12; md_data = 32'hC12;
    exp_push(5'd4, 32'h44);
    tick();
    md_issue_valid = 1'b0;
    wb_data = 32'h45;
    md_rd = 5'd13; md_data = 32'hC13;
    tick();
    wb_valid = 1'b0; md_valid = 1'b0;
    chk("pre_rst_md_ready", md_ready, 0);
    chk("pre_rst_hazard", sb_hazard, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", rf_writeenable, 0);
    chk("mid_rst_addr", rf_reg_write, 0);
    chk("mid_rst_data", rf_write_data, 0);
    chk("mid_rst_md_ready", md_ready, 1);
    chk("mid_rst_hazard", sb_hazard, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    drain("drain_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
